// File: rtl/game_session_ctl.sv
// Duck-hunt game-session controller: sequences START -> INTRO -> HUNT -> ROUND_END -> GAME_OVER
// for NUM_TARGETS targets and owns magazine, bullet, score, round, round-timer and high-score state.
// Ports: frame_tick/start_click/shot/reload/target_hit in; screen enables, target_spawn/target_alive,
//        bullets_in_magazine, bullets_left, my_score, high_score, round_num, round_time, show_reload out.
// All outputs are registered and change one cycle after the input that triggers them.
module game_session_ctl #(
   parameter int NUM_TARGETS   = 2,
   parameter int MAG_SIZE      = 3,
   parameter int TOTAL_BULLETS = 20,
   parameter int ROUNDS        = 5,
   parameter int ROUND_FRAMES  = 600,
   parameter int INTRO_FRAMES  = 120,
   parameter int SCORE_W       = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic                   start_click,
   input  logic                   shot,
   input  logic                   reload,
   input  logic [NUM_TARGETS-1:0] target_hit,
   output logic                   start_screen_enable,
   output logic                   game_enable,
   output logic                   hunt_active,
   output logic                   game_end_enable,
   output logic [NUM_TARGETS-1:0] target_spawn,
   output logic [NUM_TARGETS-1:0] target_alive,
   output logic [2:0]             bullets_in_magazine,
   output logic [6:0]             bullets_left,
   output logic [SCORE_W-1:0]     my_score,
   output logic [SCORE_W-1:0]     high_score,
   output logic [3:0]             round_num,
   output logic [11:0]            round_time,
   output logic                   show_reload
);

   typedef enum logic [2:0] {
      S_START, S_INTRO, S_HUNT, S_ROUND_END, S_GAME_OVER
   } state_t;

   localparam logic [2:0]         MAG_L    = 3'(MAG_SIZE);
   localparam logic [6:0]         TOT_L    = 7'(TOTAL_BULLETS);
   localparam logic [3:0]         ROUNDS_L = 4'(ROUNDS);
   localparam logic [11:0]        RF_L     = 12'(ROUND_FRAMES);
   localparam logic [11:0]        IF_L     = 12'(INTRO_FRAMES);
   localparam logic [SCORE_W:0]   CAP_W    = (SCORE_W+1)'(99);
   localparam logic [SCORE_W-1:0] CAP_L    = SCORE_W'(99);

   state_t                   state_q, state_d;
   logic [11:0]              cnt_q, cnt_d;
   logic [2:0]               mag_q, mag_d;
   logic [6:0]               left_q, left_d;
   logic [SCORE_W-1:0]       score_q, score_d, high_q, high_d;
   logic [3:0]               round_q, round_d;
   logic [11:0]              time_q, time_d;
   logic [NUM_TARGETS-1:0]   alive_q, alive_d, spawn_q, spawn_d;
   logic                     reload_q, reload_d;
   logic                     start_en_q, start_en_d, game_en_q, game_en_d;
   logic                     hunt_q, hunt_d, end_en_q, end_en_d;

   // HUNT-phase candidate values; only committed while in HUNT
   logic [NUM_TARGETS-1:0]   hits, alive_h;
   logic [3:0]               hit_cnt;
   logic [SCORE_W:0]         score_sum;
   logic [SCORE_W-1:0]       score_h;
   logic [2:0]               mag_h, refill;
   logic [6:0]               left_h;
   logic [11:0]              time_h;
   logic                     reload_h, round_over, pause_done;

   // A pause expires on the tick that takes the counter from 1 to 0.
   assign pause_done = frame_tick && (cnt_q <= 12'd1);

   // The magazine never holds more than the bullets that remain.
   assign refill = (left_q >= {4'b0, MAG_L}) ? MAG_L : left_q[2:0];

   always_comb begin
      hits    = target_hit & alive_q;
      hit_cnt = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         hit_cnt = hit_cnt + {3'b0, hits[i]};
      end
      score_sum = {1'b0, score_q} + (SCORE_W+1)'(hit_cnt);
      score_h   = (score_sum > CAP_W) ? CAP_L : score_sum[SCORE_W-1:0];
   end

   always_comb begin
      mag_h    = mag_q;
      left_h   = left_q;
      alive_h  = alive_q;
      reload_h = reload_q;
      time_h   = time_q;
      if (shot) begin
         // shot takes priority; a simultaneous reload is dropped
         if (mag_q != 3'd0) begin
            mag_h   = mag_q - 3'd1;
            left_h  = left_q - 7'd1;
            alive_h = alive_q & ~hits;
         end else begin
            reload_h = 1'b1;
         end
      end else if (reload) begin
         mag_h    = refill;
         reload_h = 1'b0;
      end
      if (frame_tick && (time_q != 12'd0)) begin
         time_h = time_q - 12'd1;
      end
   end

   // Round end is judged on the post-shot, post-tick values of this cycle.
   assign round_over = (alive_h == '0) || (time_h == 12'd0) || (left_h == 7'd0);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_START;
      else     state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_START:     if (start_click) state_d = S_INTRO;
         S_INTRO:     if (pause_done)  state_d = S_HUNT;
         S_HUNT:      if (round_over)  state_d = S_ROUND_END;
         S_ROUND_END: if (pause_done)
                         state_d = ((round_q == ROUNDS_L) || (left_q == 7'd0)) ? S_GAME_OVER : S_INTRO;
         S_GAME_OVER: if (start_click) state_d = S_INTRO;
         default:     state_d = S_START;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      start_en_d = (state_d == S_START);
      game_en_d  = (state_d == S_INTRO) || (state_d == S_HUNT) || (state_d == S_ROUND_END);
      hunt_d     = (state_d == S_HUNT);
      end_en_d   = (state_d == S_GAME_OVER);
      spawn_d    = ((state_q == S_INTRO) && (state_d == S_HUNT)) ? '1 : '0;
   end

   // ---------------- game data next-state ----------------
   always_comb begin
      cnt_d    = cnt_q;
      mag_d    = mag_q;
      left_d   = left_q;
      score_d  = score_q;
      high_d   = high_q;
      round_d  = round_q;
      time_d   = time_q;
      alive_d  = alive_q;
      reload_d = reload_q;
      case (state_q)
         S_START, S_GAME_OVER: begin
            if (start_click) begin
               score_d  = '0;
               round_d  = 4'd1;
               left_d   = TOT_L;
               mag_d    = MAG_L;
               reload_d = 1'b0;
               alive_d  = '0;
               cnt_d    = IF_L;
            end
         end
         S_INTRO: begin
            if (frame_tick) cnt_d = cnt_q - 12'd1;
            if (pause_done) begin
               alive_d = '1;
               time_d  = RF_L;
            end
         end
         S_HUNT: begin
            mag_d    = mag_h;
            left_d   = left_h;
            alive_d  = alive_h;
            reload_d = reload_h;
            time_d   = time_h;
            if (shot && (mag_q != 3'd0)) score_d = score_h;
            if (round_over) begin
               alive_d = '0;
               cnt_d   = IF_L;
            end
         end
         S_ROUND_END: begin
            if (frame_tick) cnt_d = cnt_q - 12'd1;
            if (pause_done) begin
               if (state_d == S_GAME_OVER) begin
                  high_d = (score_q > high_q) ? score_q : high_q;
               end else begin
                  round_d = round_q + 4'd1;
                  cnt_d   = IF_L;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         mag_q      <= MAG_L;
         left_q     <= TOT_L;
         score_q    <= '0;
         high_q     <= '0;
         round_q    <= '0;
         time_q     <= '0;
         alive_q    <= '0;
         spawn_q    <= '0;
         reload_q   <= 1'b0;
         start_en_q <= 1'b1;
         game_en_q  <= 1'b0;
         hunt_q     <= 1'b0;
         end_en_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         mag_q      <= mag_d;
         left_q     <= left_d;
         score_q    <= score_d;
         high_q     <= high_d;
         round_q    <= round_d;
         time_q     <= time_d;
         alive_q    <= alive_d;
         spawn_q    <= spawn_d;
         reload_q   <= reload_d;
         start_en_q <= start_en_d;
         game_en_q  <= game_en_d;
         hunt_q     <= hunt_d;
         end_en_q   <= end_en_d;
      end
   end

   assign start_screen_enable = start_en_q;
   assign game_enable         = game_en_q;
   assign hunt_active         = hunt_q;
   assign game_end_enable     = end_en_q;
   assign target_spawn        = spawn_q;
   assign target_alive        = alive_q;
   assign bullets_in_magazine = mag_q;
   assign bullets_left        = left_q;
   assign my_score            = score_q;
   assign high_score          = high_q;
   assign round_num           = round_q;
   assign round_time          = time_q;
   assign show_reload         = reload_q;

endmodule

// File: tb/tb_game_session_ctl.sv
// Bench for game_session_ctl: three instances with different parameter sets, driven one at a time
// and compared every cycle against a rule-level reference model of the game.
module tb_game_session_ctl;

   localparam int P_START = 0, P_INTRO = 1, P_HUNT = 2, P_END = 3, P_OVER = 4;

   // parameter sets: 0 = defaults, 1 = many targets/rounds (score saturation), 2 = few bullets
   int p_n[3]      = '{2, 8, 2};
   int p_mag[3]    = '{3, 7, 3};
   int p_tot[3]    = '{20, 99, 4};
   int p_rounds[3] = '{5, 15, 5};
   int p_rf[3]     = '{600, 50, 600};
   int p_if[3]     = '{120, 4, 3};

   typedef struct packed {
      logic        sse, ge, ha, gee, sr;
      logic [7:0]  spawn, alive;
      logic [2:0]  mag;
      logic [6:0]  left, score, high;
      logic [3:0]  round;
      logic [11:0] rtime;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   logic ft[3], sc[3], sh[3], rl[3];
   logic [7:0] hit[3];
   int n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   // ---------------- DUT 0 ----------------
   logic w0_sse, w0_ge, w0_ha, w0_gee, w0_sr;
   logic [1:0] w0_spawn, w0_alive;
   logic [2:0] w0_mag;
   logic [6:0] w0_left, w0_score, w0_high;
   logic [3:0] w0_round;
   logic [11:0] w0_time;
   obs_t ob0;
   assign ob0 = {w0_sse, w0_ge, w0_ha, w0_gee, w0_sr, {6'b0, w0_spawn}, {6'b0, w0_alive},
                 w0_mag, w0_left, w0_score, w0_high, w0_round, w0_time};

   game_session_ctl #(.NUM_TARGETS(2), .MAG_SIZE(3), .TOTAL_BULLETS(20), .ROUNDS(5),
                      .ROUND_FRAMES(600), .INTRO_FRAMES(120), .SCORE_W(7)) u_dut0 (
      .clk(clk), .rst(rst), .frame_tick(ft[0]), .start_click(sc[0]), .shot(sh[0]), .reload(rl[0]),
      .target_hit(hit[0][1:0]), .start_screen_enable(w0_sse), .game_enable(w0_ge),
      .hunt_active(w0_ha), .game_end_enable(w0_gee), .target_spawn(w0_spawn),
      .target_alive(w0_alive), .bullets_in_magazine(w0_mag), .bullets_left(w0_left),
      .my_score(w0_score), .high_score(w0_high), .round_num(w0_round), .round_time(w0_time),
      .show_reload(w0_sr));

   // ---------------- DUT 1 ----------------
   logic w1_sse, w1_ge, w1_ha, w1_gee, w1_sr;
   logic [7:0] w1_spawn, w1_alive;
   logic [2:0] w1_mag;
   logic [6:0] w1_left, w1_score, w1_high;
   logic [3:0] w1_round;
   logic [11:0] w1_time;
   obs_t ob1;
   assign ob1 = {w1_sse, w1_ge, w1_ha, w1_gee, w1_sr, w1_spawn, w1_alive,
                 w1_mag, w1_left, w1_score, w1_high, w1_round, w1_time};

   game_session_ctl #(.NUM_TARGETS(8), .MAG_SIZE(7), .TOTAL_BULLETS(99), .ROUNDS(15),
                      .ROUND_FRAMES(50), .INTRO_FRAMES(4), .SCORE_W(7)) u_dut1 (
      .clk(clk), .rst(rst), .frame_tick(ft[1]), .start_click(sc[1]), .shot(sh[1]), .reload(rl[1]),
      .target_hit(hit[1]), .start_screen_enable(w1_sse), .game_enable(w1_ge),
      .hunt_active(w1_ha), .game_end_enable(w1_gee), .target_spawn(w1_spawn),
      .target_alive(w1_alive), .bullets_in_magazine(w1_mag), .bullets_left(w1_left),
      .my_score(w1_score), .high_score(w1_high), .round_num(w1_round), .round_time(w1_time),
      .show_reload(w1_sr));

   // ---------------- DUT 2 ----------------
   logic w2_sse, w2_ge, w2_ha, w2_gee, w2_sr;
   logic [1:0] w2_spawn, w2_alive;
   logic [2:0] w2_mag;
   logic [6:0] w2_left, w2_score, w2_high;
   logic [3:0] w2_round;
   logic [11:0] w2_time;
   obs_t ob2;
   assign ob2 = {w2_sse, w2_ge, w2_ha, w2_gee, w2_sr, {6'b0, w2_spawn}, {6'b0, w2_alive},
                 w2_mag, w2_left, w2_score, w2_high, w2_round, w2_time};

   game_session_ctl #(.NUM_TARGETS(2), .MAG_SIZE(3), .TOTAL_BULLETS(4), .ROUNDS(5),
                      .ROUND_FRAMES(600), .INTRO_FRAMES(3), .SCORE_W(7)) u_dut2 (
      .clk(clk), .rst(rst), .frame_tick(ft[2]), .start_click(sc[2]), .shot(sh[2]), .reload(rl[2]),
      .target_hit(hit[2][1:0]), .start_screen_enable(w2_sse), .game_enable(w2_ge),
      .hunt_active(w2_ha), .game_end_enable(w2_gee), .target_spawn(w2_spawn),
      .target_alive(w2_alive), .bullets_in_magazine(w2_mag), .bullets_left(w2_left),
      .my_score(w2_score), .high_score(w2_high), .round_num(w2_round), .round_time(w2_time),
      .show_reload(w2_sr));

   // ---------------- reference model ----------------
   int m_st[3], m_cnt[3], m_mag[3], m_left[3], m_score[3], m_high[3], m_round[3], m_time[3];
   bit m_sr[3];
   logic [7:0] m_alive[3], m_spawn[3];

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset(input int k);
      m_st[k] = P_START; m_cnt[k] = 0; m_mag[k] = p_mag[k]; m_left[k] = p_tot[k];
      m_score[k] = 0; m_high[k] = 0; m_round[k] = 0; m_time[k] = 0; m_sr[k] = 0;
      m_alive[k] = 8'h00; m_spawn[k] = 8'h00;
   endtask

   task automatic new_game(input int k);
      m_score[k] = 0; m_round[k] = 1; m_left[k] = p_tot[k]; m_mag[k] = p_mag[k];
      m_sr[k] = 0; m_alive[k] = 8'h00; m_st[k] = P_INTRO; m_cnt[k] = p_if[k];
   endtask

   task automatic model_step(input int k, input bit f, input bit s, input bit h, input bit r,
                             input logic [7:0] th);
      logic [7:0] mask, hits;
      mask = 8'hFF >> (8 - p_n[k]);
      m_spawn[k] = 8'h00;
      case (m_st[k])
         P_START, P_OVER: if (s) new_game(k);
         P_INTRO: if (f) begin
            m_cnt[k] = m_cnt[k] - 1;
            if (m_cnt[k] == 0) begin
               m_st[k] = P_HUNT; m_spawn[k] = mask; m_alive[k] = mask; m_time[k] = p_rf[k];
            end
         end
         P_HUNT: begin
            if (h) begin
               if (m_mag[k] > 0) begin
                  m_mag[k] = m_mag[k] - 1;
                  m_left[k] = m_left[k] - 1;
                  hits = th & m_alive[k];
                  m_score[k] = imin(99, m_score[k] + $countones(hits));
                  m_alive[k] = m_alive[k] & ~hits;
               end else begin
                  m_sr[k] = 1;
               end
            end else if (r) begin
               m_mag[k] = imin(p_mag[k], m_left[k]);
               m_sr[k] = 0;
            end
            if (f && m_time[k] > 0) m_time[k] = m_time[k] - 1;
            if (m_alive[k] == 8'h00 || m_time[k] == 0 || m_left[k] == 0) begin
               m_st[k] = P_END; m_alive[k] = 8'h00; m_cnt[k] = p_if[k];
            end
         end
         P_END: if (f) begin
            m_cnt[k] = m_cnt[k] - 1;
            if (m_cnt[k] == 0) begin
               if (m_round[k] == p_rounds[k] || m_left[k] == 0) begin
                  m_st[k] = P_OVER;
                  if (m_score[k] > m_high[k]) m_high[k] = m_score[k];
               end else begin
                  m_round[k] = m_round[k] + 1; m_st[k] = P_INTRO; m_cnt[k] = p_if[k];
               end
            end
         end
         default: ;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input longint got, input longint exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic obs_t get_obs(input int k);
      case (k)
         0:       return ob0;
         1:       return ob1;
         default: return ob2;
      endcase
   endfunction

   task automatic check_all(input int k);
      obs_t o;
      string p;
      o = get_obs(k);
      p = $sformatf("d%0d.", k);
      chk({p, "start_screen_enable"}, o.sse, m_st[k] == P_START);
      chk({p, "game_enable"}, o.ge, m_st[k] == P_INTRO || m_st[k] == P_HUNT || m_st[k] == P_END);
      chk({p, "hunt_active"}, o.ha, m_st[k] == P_HUNT);
      chk({p, "game_end_enable"}, o.gee, m_st[k] == P_OVER);
      chk({p, "target_spawn"}, o.spawn, m_spawn[k]);
      chk({p, "target_alive"}, o.alive, m_alive[k]);
      chk({p, "bullets_in_magazine"}, o.mag, m_mag[k]);
      chk({p, "bullets_left"}, o.left, m_left[k]);
      chk({p, "my_score"}, o.score, m_score[k]);
      chk({p, "high_score"}, o.high, m_high[k]);
      chk({p, "round_num"}, o.round, m_round[k]);
      chk({p, "round_time"}, o.rtime, m_time[k]);
      chk({p, "show_reload"}, o.sr, m_sr[k]);
   endtask

   // one clock of stimulus to instance k, then compare that instance against the model
   task automatic step(input int k, input bit f, input bit s, input bit h, input bit r,
                       input logic [7:0] th);
      @(negedge clk);
      ft[k] = f; sc[k] = s; sh[k] = h; rl[k] = r; hit[k] = th;
      @(posedge clk);
      model_step(k, f, s, h, r, th);
      #1;
      ft[k] = 1'b0; sc[k] = 1'b0; sh[k] = 1'b0; rl[k] = 1'b0; hit[k] = 8'h00;
      check_all(k);
   endtask

   task automatic run_until(input int k, input int ph, input int budget);
      for (int i = 0; i < budget && m_st[k] != ph; i++) step(k, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      if (m_st[k] != ph) chk($sformatf("d%0d.timeout_phase%0d", k, ph), 0, 1);
   endtask

   initial begin
      obs_t o;
      int n, h1;
      bit f;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ft[k] = 1'b0; sc[k] = 1'b0; sh[k] = 1'b0; rl[k] = 1'b0; hit[k] = 8'h00;
         model_reset(k);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) check_all(k);

      // ---- instance 2: bullets run out before the last round ----
      step(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      run_until(2, P_HUNT, 50);
      repeat (3) step(2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step(2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      o = get_obs(2);
      chk("d2.partial_refill", o.mag, 1);
      step(2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
      o = get_obs(2);
      chk("d2.last_bullet_left", o.left, 0);
      chk("d2.last_bullet_hunt", o.ha, 0);
      chk("d2.last_bullet_score", o.score, 1);
      run_until(2, P_OVER, 50);
      o = get_obs(2);
      chk("d2.early_over", o.gee, 1);
      chk("d2.early_over_round", o.round, 1);
      chk("d2.early_over_high", o.high, 1);

      // ---- instance 1: score saturation over many rounds ----
      step(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n = 0;
      while (m_st[1] != P_OVER && n < 20000) begin
         f = 1'($urandom_range(0, 1));
         if (m_st[1] != P_HUNT)    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
         else if (m_mag[1] == 0)   step(1, f, 1'b0, 1'b0, 1'b1, 8'h00);
         else                      step(1, f, 1'b0, 1'b1, 1'b0, 8'hFF);
         n++;
      end
      if (m_st[1] != P_OVER) chk("d1.timeout_game_over", 0, 1);
      o = get_obs(1);
      chk("d1.score_saturated", o.score, 99);
      chk("d1.high_saturated", o.high, 99);
      chk("d1.final_round", o.round, 15);

      // ---- instance 0: directed opening ----
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      o = get_obs(0);
      chk("d0.intro_game_enable", o.ge, 1);
      chk("d0.intro_round", o.round, 1);
      repeat (120) step(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      o = get_obs(0);
      chk("d0.hunt_entry", o.ha, 1);
      chk("d0.spawn_pulse", o.spawn, 3);
      chk("d0.round_time_load", o.rtime, 600);
      step(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
      o = get_obs(0);
      chk("d0.double_hit_score", o.score, 2);
      chk("d0.double_hit_mag", o.mag, 2);
      chk("d0.double_hit_left", o.left, 19);
      chk("d0.double_hit_round_end", o.ha, 0);
      step(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
      o = get_obs(0);
      chk("d0.ignored_shot_score", o.score, 2);
      run_until(0, P_HUNT, 400);
      step(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      repeat (4) step(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      o = get_obs(0);
      chk("d0.dry_fire_flag", o.sr, 1);
      chk("d0.dry_fire_left", o.left, 16);
      step(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      o = get_obs(0);
      chk("d0.reload_mag", o.mag, 3);
      chk("d0.reload_clears_flag", o.sr, 0);
      step(0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      o = get_obs(0);
      chk("d0.shot_beats_reload", o.mag, 2);

      // ---- instance 0: randomized play to game over ----
      n = 0;
      while (m_st[0] != P_OVER && n < 30000) begin
         step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0, 8'($urandom_range(0, 3)));
         n++;
      end
      if (m_st[0] != P_OVER) chk("d0.timeout_game1", 0, 1);
      h1 = m_score[0];
      o = get_obs(0);
      chk("d0.high_after_game1", o.high, h1);

      // ---- instance 0: second game, every round times out ----
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      o = get_obs(0);
      chk("d0.restart_score", o.score, 0);
      chk("d0.restart_keeps_high", o.high, h1);
      run_until(0, P_OVER, 6000);
      o = get_obs(0);
      chk("d0.game2_over", o.gee, 1);
      chk("d0.game2_rounds", o.round, 5);
      chk("d0.game2_high_kept", o.high, h1);

      // ---- instance 0: third game, tick with shot, then asynchronous reset mid-hunt ----
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      run_until(0, P_HUNT, 400);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
      o = get_obs(0);
      chk("d0.tick_with_shot_time", o.rtime, 599);
      chk("d0.tick_with_shot_score", o.score, 1);
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         model_reset(k);
         check_all(k);
      end
      o = get_obs(0);
      chk("d0.async_rst_high", o.high, 0);
      chk("d0.async_rst_start_screen", o.sse, 1);
      @(negedge clk);
      rst = 1'b0;
      step(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
